led_pwm_bank: RTL and testbench
===============================

// Module: led_pwm_bank
// PURPOSE
//  Multi-channel LED driver; successor to the single free-running-counter blinker.
//  Shared prescaler + PWM phase counter drive NCH channels.
//  Each channel is independently OFF, ON, PWM (duty) or BLINK (toggle per period).
//  Config writes are shadowed and applied glitch-free at the next PWM period boundary.
// PARAMETERS
//  NCH      4  number of LED channels (1..16)
//  PRESC_W  8  prescaler width; one PWM tick every 2**PRESC_W clocks
//  DUTY_W   8  PWM resolution; period = 2**DUTY_W ticks
// PORTS
//  i_clk      in   1             system clock, all logic rising-edge
//  i_reset_n  in   1             asynchronous active-low reset
//  i_wr_stb   in   1             config write strobe, one-cycle pulse, no backpressure
//  i_wr_ch    in   $clog2(NCH)+1 target channel index
//  i_wr_mode  in   2             00 OFF, 01 ON, 10 PWM, 11 BLINK
//  i_wr_duty  in   DUTY_W        PWM duty (ignored for other modes)
//  o_wr_err   out  1             1-cycle pulse: write to channel index >= NCH
//  o_pending  out  NCH           1 while channel holds a not-yet-applied write
//  o_phase    out  DUTY_W        current PWM phase counter (debug)
//  o_led      out  NCH           registered LED outputs
// BEHAVIOUR
//  Reset (async assert, sync release): prescaler=0, phase=0, all modes OFF,
//   duty=0, blink state=0, o_led=0, o_pending=0, o_wr_err=0.
//  Prescaler: free-running PRESC_W counter, wraps; tick = (presc == all-ones).
//  Phase: increments by 1 on tick, wraps 2**DUTY_W-1 -> 0.
//  Boundary = tick && phase == all-ones (cycle before phase returns to 0).
//  Write: i_wr_stb with i_wr_ch < NCH loads pending {mode,duty}, sets o_pending[ch]
//   next cycle; i_wr_ch >= NCH: no state change, o_wr_err pulses next cycle.
//  Rewrite while pending overwrites pending value; last write wins.
//  Apply: on boundary, every pending channel copies pending -> active, clears o_pending.
//  Write in the same cycle as boundary: previous pending (if any) applied now;
//   new write becomes pending and applies at the following boundary.
//  Output (1-cycle registered): OFF -> 0; ON -> 1; PWM -> (phase < duty);
//   BLINK -> blink state, which toggles on every boundary while active mode is BLINK,
//   clears to 0 when a non-BLINK mode is applied.
//  duty=0 -> constantly 0; duty=2**DUTY_W-1 -> 0 for exactly one phase step per period.
//  Comparisons unsigned, DUTY_W bits; no saturation or overflow flags needed.
//  Reset mid-operation: all pending writes discarded; no partial state retained.
// STRUCTURE
//  Package blinky_pkg: localparam MODE_OFF/ON/PWM/BLINK (2-bit), mode typedef width.
//  Top holds prescaler, phase counter, boundary detect, write decode, o_wr_err.
//  Sub-module led_pwm_channel (instantiated NCH times via generate): pending/active
//   regs, o_pending bit, blink state, registered o_led bit; inputs tick/boundary/phase.
// TESTING  (PRESC_W=2, DUTY_W=3, NCH=2: tick every 4 clk, period 32 clk)
//  Reset release, no writes, 200 clk -> o_led=00, o_pending=00, o_phase counts 0..7.
//  Write ch0 PWM duty=3 -> o_pending[0]=1 until boundary; then o_led[0] high
//   12 clk / low 20 clk per 32-clk period, aligned one clk after phase 0.
//  Write ch1 BLINK -> after apply, o_led[1] toggles every 32 clk, starts from 1.
//  Write ch0 ON then ch0 OFF before boundary -> only OFF applied; o_led[0] stays 0.
//  Write on exact boundary cycle -> applied one period (32 clk) later, not now.
//  Write ch=2 -> o_wr_err pulses 1 clk, o_pending and o_led unchanged;
//   assert i_reset_n=0 with pending write mid-period -> all outputs 0 immediately.

Source files
------------

// File: rtl/blinky_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : blinky_pkg
// Brief  : Shared LED channel mode encoding for the PWM LED bank.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package blinky_pkg;
  localparam int MODE_W = 2;
  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_OFF   = 2'b00;
  localparam mode_t MODE_ON    = 2'b01;
  localparam mode_t MODE_PWM   = 2'b10;
  localparam mode_t MODE_BLINK = 2'b11;
endpackage
`default_nettype wire

// File: rtl/led_pwm_channel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : led_pwm_channel
// Brief  : One LED channel: shadowed config, boundary apply, registered LED.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module led_pwm_channel
  import blinky_pkg::*;
#(
  parameter int DUTY_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wr_en,
  input  mode_t             i_wr_mode,
  input  logic [DUTY_W-1:0] i_wr_duty,
  input  logic              i_boundary,
  input  logic [DUTY_W-1:0] i_phase,
  output logic              o_pending,
  output logic              o_led
);

  mode_t             r_pend_mode;
  logic [DUTY_W-1:0] r_pend_duty;
  logic              r_pending;
  mode_t             r_act_mode;
  logic [DUTY_W-1:0] r_act_duty;
  logic              r_blink;
  logic              r_led;

  mode_t             w_next_mode;
  logic              w_led_nxt;

  // Mode that will be active after this boundary (pending wins if present).
  assign w_next_mode = r_pending ? r_pend_mode : r_act_mode;

  always_comb begin
    w_led_nxt = 1'b0;
    case (r_act_mode)
      MODE_OFF:   w_led_nxt = 1'b0;
      MODE_ON:    w_led_nxt = 1'b1;
      MODE_PWM:   w_led_nxt = (i_phase < r_act_duty);
      MODE_BLINK: w_led_nxt = r_blink;
      default:    w_led_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pend_mode <= MODE_OFF;
      r_pend_duty <= '0;
      r_pending   <= 1'b0;
      r_act_mode  <= MODE_OFF;
      r_act_duty  <= '0;
      r_blink     <= 1'b0;
      r_led       <= 1'b0;
    end else begin
      if (i_boundary) begin
        if (r_pending) begin
          r_act_mode <= r_pend_mode;
          r_act_duty <= r_pend_duty;
        end
        r_blink <= (w_next_mode == MODE_BLINK) ? ~r_blink : 1'b0;
      end
      // A write landing on the boundary cycle becomes the next pending value.
      if (i_wr_en) begin
        r_pend_mode <= i_wr_mode;
        r_pend_duty <= i_wr_duty;
        r_pending   <= 1'b1;
      end else if (i_boundary) begin
        r_pending   <= 1'b0;
      end
      r_led <= w_led_nxt;
    end
  end

  assign o_pending = r_pending;
  assign o_led     = r_led;

endmodule
`default_nettype wire

// File: rtl/led_pwm_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : led_pwm_bank
// Brief  : Multi-channel LED driver with shared prescaler and PWM phase.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module led_pwm_bank
  import blinky_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int PRESC_W = 8,
  parameter int DUTY_W  = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_wr_stb,
  input  logic [$clog2(NCH):0]   i_wr_ch,
  input  logic [1:0]             i_wr_mode,
  input  logic [DUTY_W-1:0]      i_wr_duty,
  output logic                   o_wr_err,
  output logic [NCH-1:0]         o_pending,
  output logic [DUTY_W-1:0]      o_phase,
  output logic [NCH-1:0]         o_led
);

  localparam int              CH_W   = $clog2(NCH) + 1;
  localparam logic [CH_W-1:0] NCH_CH = CH_W'(NCH);

  logic [PRESC_W-1:0] r_presc;
  logic [DUTY_W-1:0]  r_phase;
  logic               r_wr_err;

  logic               w_tick;
  logic               w_boundary;
  logic               w_ch_ok;

  assign w_tick     = &r_presc;
  assign w_boundary = w_tick && (&r_phase);
  assign w_ch_ok    = (i_wr_ch < NCH_CH);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_presc  <= '0;
      r_phase  <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_presc  <= r_presc + 1'b1;
      if (w_tick) begin
        r_phase <= r_phase + 1'b1;
      end
      r_wr_err <= i_wr_stb && !w_ch_ok;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic w_wr_en;
    assign w_wr_en = i_wr_stb && w_ch_ok && (i_wr_ch == CH_W'(g));

    led_pwm_channel #(
      .DUTY_W (DUTY_W)
    ) u_ch (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_wr_en    (w_wr_en),
      .i_wr_mode  (mode_t'(i_wr_mode)),
      .i_wr_duty  (i_wr_duty),
      .i_boundary (w_boundary),
      .i_phase    (r_phase),
      .o_pending  (o_pending[g]),
      .o_led      (o_led[g])
    );
  end

  assign o_wr_err = r_wr_err;
  assign o_phase  = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_led_pwm_bank
// Brief  : Scoreboard bench for led_pwm_bank (NCH=2, PRESC_W=2, DUTY_W=3).
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_led_pwm_bank;
  import blinky_pkg::*;

  localparam int NCH     = 2;
  localparam int PRESC_W = 2;
  localparam int DUTY_W  = 3;

  localparam int K_LED   = 0;
  localparam int K_LEDB  = 1;
  localparam int K_PEND  = 2;
  localparam int K_PHASE = 3;
  localparam int K_ERR   = 4;

  typedef struct {
    int    cyc;
    int    kind;
    int    idx;
    int    val;
    string name;
  } exp_t;

  logic              i_clk     = 1'b0;
  logic              i_reset_n = 1'b0;
  logic              i_wr_stb  = 1'b0;
  logic [1:0]        i_wr_ch   = '0;
  logic [1:0]        i_wr_mode = '0;
  logic [DUTY_W-1:0] i_wr_duty = '0;
  logic              o_wr_err;
  logic [NCH-1:0]    o_pending;
  logic [DUTY_W-1:0] o_phase;
  logic [NCH-1:0]    o_led;

  exp_t        q[$];
  exp_t        m_e;
  logic [31:0] m_act;
  int          cyc     = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  led_pwm_bank #(
    .NCH     (NCH),
    .PRESC_W (PRESC_W),
    .DUTY_W  (DUTY_W)
  ) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_wr_stb  (i_wr_stb),
    .i_wr_ch   (i_wr_ch),
    .i_wr_mode (i_wr_mode),
    .i_wr_duty (i_wr_duty),
    .o_wr_err  (o_wr_err),
    .o_pending (o_pending),
    .o_phase   (o_phase),
    .o_led     (o_led)
  );

  always #5 i_clk = ~i_clk;

  // Rising edges since reset release; cycle k = state after the k-th edge.
  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) cyc <= 0;
    else            cyc <= cyc + 1;
  end

  task automatic exp_push(input int c, input int kind, input int idx,
                          input int val, input string name);
    exp_t e;
    int   p;
    e.cyc = c; e.kind = kind; e.idx = idx; e.val = val; e.name = name;
    p = q.size();
    while (p > 0 && q[p-1].cyc > c) p--;
    q.insert(p, e);
  endtask

  task automatic wait_to(input int k);
    while (cyc < k) @(negedge i_clk);
  endtask

  task automatic wr_at(input int k, input logic [1:0] ch, input logic [1:0] mode,
                       input logic [DUTY_W-1:0] duty);
    wait_to(k);
    i_wr_stb  = 1'b1;
    i_wr_ch   = ch;
    i_wr_mode = mode;
    i_wr_duty = duty;
    @(negedge i_clk);
    i_wr_stb  = 1'b0;
  endtask

  // Monitor: compares every expectation due at the current cycle.
  always @(negedge i_clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      n_tests++;
      if (m_e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: stale check due cyc %0d seen at cyc %0d", m_e.name, m_e.cyc, cyc);
      end else begin
        case (m_e.kind)
          K_LED:   m_act = 32'(o_led);
          K_LEDB:  m_act = 32'(o_led[m_e.idx]);
          K_PEND:  m_act = 32'(o_pending);
          K_PHASE: m_act = 32'(o_phase);
          default: m_act = 32'(o_wr_err);
        endcase
        if (m_act !== m_e.val) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %0h expected %0h", m_e.name, cyc, m_act, m_e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    exp_push(0, K_LED,   0, 0, "rst_led");
    exp_push(0, K_PEND,  0, 0, "rst_pend");
    exp_push(0, K_PHASE, 0, 0, "rst_phase");
    exp_push(0, K_ERR,   0, 0, "rst_err");
    #32 i_reset_n = 1'b1;

    // Idle: phase = (cyc/4) mod 8, LEDs and pending stay low
    exp_push(3,   K_PHASE, 0, 0, "idle_phase3");
    exp_push(4,   K_PHASE, 0, 1, "idle_phase4");
    exp_push(13,  K_PHASE, 0, 3, "idle_phase13");
    exp_push(31,  K_PHASE, 0, 7, "idle_phase31");
    exp_push(32,  K_PHASE, 0, 0, "idle_wrap32");
    exp_push(45,  K_PHASE, 0, 3, "idle_phase45");
    exp_push(100, K_LED,   0, 0, "idle_led100");
    exp_push(200, K_LED,   0, 0, "idle_led200");
    exp_push(200, K_PEND,  0, 0, "idle_pend200");

    // ch0 PWM duty 3: pending until boundary at 223, high 12 / low 20
    exp_push(202, K_PEND, 0, 1, "pwm_pend_set");
    exp_push(223, K_PEND, 0, 1, "pwm_pend_hold");
    exp_push(224, K_PEND, 0, 0, "pwm_pend_clr");
    exp_push(224, K_LED,  0, 0, "pwm_led_preapply");
    exp_push(225, K_LED,  0, 1, "pwm_led_rise");
    exp_push(236, K_LED,  0, 1, "pwm_led_last_hi");
    exp_push(237, K_LED,  0, 0, "pwm_led_fall");
    exp_push(256, K_LED,  0, 0, "pwm_led_last_lo");
    exp_push(257, K_LED,  0, 1, "pwm_led_rise2");
    wr_at(201, 2'd0, MODE_PWM, 3'd3);

    // ch1 BLINK: applied at edge 288, starts at 1, toggles every 32 clk
    exp_push(261, K_PEND, 0, 2, "blk_pend_set");
    exp_push(287, K_PEND, 0, 2, "blk_pend_hold");
    exp_push(288, K_PEND, 0, 0, "blk_pend_clr");
    exp_push(288, K_LEDB, 1, 0, "blk_preapply");
    exp_push(289, K_LEDB, 1, 1, "blk_first_on");
    exp_push(320, K_LEDB, 1, 1, "blk_hold_on");
    exp_push(321, K_LEDB, 1, 0, "blk_toggle_off");
    exp_push(352, K_LEDB, 1, 0, "blk_hold_off");
    exp_push(353, K_LEDB, 1, 1, "blk_toggle_on");
    wr_at(260, 2'd1, MODE_BLINK, 3'd0);

    // ch0 ON then OFF before boundary: only OFF applied at edge 384
    exp_push(361, K_PEND, 0, 1, "lw_pend_set");
    exp_push(383, K_PEND, 0, 1, "lw_pend_hold");
    exp_push(384, K_PEND, 0, 0, "lw_pend_clr");
    exp_push(385, K_LEDB, 0, 0, "lw_led385");
    exp_push(386, K_LEDB, 0, 0, "lw_led386");
    exp_push(395, K_LEDB, 0, 0, "lw_led395");
    wr_at(360, 2'd0, MODE_ON,  3'd0);
    wr_at(370, 2'd0, MODE_OFF, 3'd0);

    // ch0 PWM duty 7 pending, then ON written on boundary cycle 415:
    // duty 7 applies at 416 (low one phase step), ON applies at 448
    exp_push(401, K_PEND, 0, 1, "bd_pend_first");
    exp_push(416, K_PEND, 0, 1, "bd_pend_new");
    exp_push(416, K_LEDB, 0, 0, "bd_led416");
    exp_push(417, K_LEDB, 0, 1, "bd_pwm7_hi");
    exp_push(444, K_LEDB, 0, 1, "bd_pwm7_last_hi");
    exp_push(445, K_LEDB, 0, 0, "bd_pwm7_lo");
    exp_push(447, K_PEND, 0, 1, "bd_pend_hold");
    exp_push(448, K_PEND, 0, 0, "bd_pend_clr");
    exp_push(448, K_LEDB, 0, 0, "bd_pwm7_lo_end");
    exp_push(449, K_LEDB, 0, 1, "bd_on_applied");
    exp_push(460, K_LEDB, 0, 1, "bd_on_hold");
    wr_at(400, 2'd0, MODE_PWM, 3'd7);
    wr_at(415, 2'd0, MODE_ON,  3'd0);

    // Out-of-range channels: error pulse only
    exp_push(470, K_ERR,  0, 0, "err_idle");
    exp_push(471, K_ERR,  0, 1, "err_ch2_pulse");
    exp_push(471, K_PEND, 0, 0, "err_ch2_pend");
    exp_push(471, K_LED,  0, 1, "err_ch2_led");
    exp_push(472, K_ERR,  0, 0, "err_ch2_end");
    exp_push(476, K_ERR,  0, 1, "err_ch3_pulse");
    exp_push(476, K_PEND, 0, 0, "err_ch3_pend");
    exp_push(477, K_ERR,  0, 0, "err_ch3_end");
    wr_at(470, 2'd2, MODE_ON, 3'd5);
    wr_at(475, 2'd3, MODE_PWM, 3'd2);

    // Reset mid-period with ch1 write pending
    exp_push(491, K_PEND, 0, 2, "rr_pend_set");
    wr_at(490, 2'd1, MODE_ON, 3'd0);
    wait_to(495);
    #2 i_reset_n = 1'b0;
    exp_push(0, K_LED,   0, 0, "rr_led");
    exp_push(0, K_PEND,  0, 0, "rr_pend");
    exp_push(0, K_PHASE, 0, 0, "rr_phase");
    exp_push(0, K_ERR,   0, 0, "rr_err");
    exp_push(40, K_PEND,  0, 0, "rr_pend40");
    exp_push(40, K_LED,   0, 0, "rr_led40");
    exp_push(70, K_LED,   0, 0, "rr_led70");
    exp_push(70, K_PEND,  0, 0, "rr_pend70");
    exp_push(70, K_PHASE, 0, 1, "rr_phase70");
    @(negedge i_clk);
    @(negedge i_clk);
    #2 i_reset_n = 1'b1;

    for (int i = 0; i < 300 && q.size() > 0; i++) @(negedge i_clk);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checks left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
